// File: rtl/ebus_responder_pkg.sv
// ebus_responder_pkg: shared EBUS definitions for the generic responder.
// Holds the function code enum, bus widths, CONI register bit positions,
// the handshake state encoding and small decode helpers.
package ebus_responder_pkg;

    localparam int CS_W   = 7;
    localparam int DATA_W = 36;
    localparam int CNT_W  = 4;

    // CONO/CONI register bit positions, in EBUS bit numbering (bit 0 = MSB).
    localparam int CON_IE_BIT       = 30;
    localparam int CON_CLR_DONE_BIT = 31;
    localparam int CON_DONE_BIT     = 32;
    localparam int CON_PIA_MSB      = 33;
    localparam int CON_PIA_LSB      = 35;

    typedef enum logic [2:0] {
        FUNC_CONO  = 3'd0,
        FUNC_CONI  = 3'd1,
        FUNC_DATAO = 3'd2,
        FUNC_DATAI = 3'd3
    } ebus_func_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_RELEASE
    } resp_state_e;

    // Function codes 4..7 are never answered by this device.
    function automatic logic func_answered(input logic [2:0] func);
        return ~func[2];
    endfunction

    // CONI and DATAI put data on the bus; CONO and DATAO take it.
    function automatic logic func_is_read(input ebus_func_e func);
        return (func == FUNC_CONI) || (func == FUNC_DATAI);
    endfunction

endpackage

// File: rtl/ebus_responder_fsm.sv
// ebus_responder_fsm: demand/xfer handshake sequencer for the EBUS responder.
// Accepts a demand addressed to DEV_CS, waits XFER_DELAY cycles, raises xfer
// (and drvEn for reads) until demand drops, then releases the bus.
module ebus_responder_fsm
    import ebus_responder_pkg::*;
#(
    parameter logic [0:CS_W-1] DEV_CS     = 7'o0,
    parameter int unsigned     XFER_DELAY = 2     // 0..15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [0:CS_W-1] cs_i,
    input  logic [0:2]      func_i,
    input  logic            demand_i,
    output ebus_func_e      func_o,
    output logic            xfer_o,
    output logic            drv_en_o,
    output logic            enter_xfer_o,
    output logic            leave_xfer_o
);

    localparam logic [CNT_W-1:0] DELAY_INIT = CNT_W'(XFER_DELAY);

    resp_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    ebus_func_e       func_q;
    logic             xfer_q;
    logic             drv_en_q;
    logic             accept;

    assign accept = (state_q == ST_IDLE) && demand_i && (cs_i == DEV_CS)
                    && func_answered(func_i);

    // Strobes for the register file: the edge that enters XFER performs the
    // write or captures read data; the edge that leaves XFER clears the bus.
    assign enter_xfer_o = (state_q == ST_WAIT) && demand_i && (cnt_q == '0);
    assign leave_xfer_o = (state_q == ST_XFER) && !demand_i;

    assign func_o   = func_q;
    assign xfer_o   = xfer_q;
    assign drv_en_o = drv_en_q;

    // Handshake state, delay counter, latched function and registered bus outputs.
    // A zero delay still spends one cycle in WAIT, so xfer always rises
    // XFER_DELAY+1 edges after the edge that accepted the demand.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            func_q   <= FUNC_CONO;
            xfer_q   <= 1'b0;
            drv_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        func_q  <= ebus_func_e'(func_i);
                        cnt_q   <= DELAY_INIT;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!demand_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q  <= ST_XFER;
                        xfer_q   <= 1'b1;
                        drv_en_q <= func_is_read(func_q);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    if (!demand_i) begin
                        state_q  <= ST_RELEASE;
                        xfer_q   <= 1'b0;
                        drv_en_q <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ebus_responder.sv
// ebus_responder: generic KL10 EBUS I/O device (target end of EBUS transfers).
// Sinks CONO/DATAO into conReg/datReg, sources CONI/DATAI onto the bus and
// raises a PI request on its assigned level when done and enabled.
// Optional bus parity is built when EBUS_RESP_PARITY_EN is defined.
module ebus_responder
    import ebus_responder_pkg::*;
#(
    parameter logic [0:CS_W-1] DEV_CS     = 7'o0,
    parameter int unsigned     XFER_DELAY = 2
) (
    input  logic              eboxClk,
    input  logic              eboxReset,
    input  logic [0:CS_W-1]   EBUS_cs,
    input  logic [0:2]        EBUS_func,
    input  logic              EBUS_demand,
    input  logic [0:DATA_W-1] EBUS_dataIn,
`ifdef EBUS_RESP_PARITY_EN
    input  logic              EBUS_parityIn,
    output logic              drvParity,
    output logic              parityErr,
`endif
    output logic [0:DATA_W-1] drvData,
    output logic              drvEn,
    output logic              xfer,
    output logic [0:7]        piReq,
    output logic [18:35]      conReg,
    output logic [0:DATA_W-1] datReg
);

    ebus_func_e        func;
    logic              enter_xfer;
    logic              leave_xfer;
    logic              ie_q;
    logic              done_q;
    logic [2:0]        pia_q;
    logic [0:DATA_W-1] dat_q;
    logic [0:DATA_W-1] drv_data_q;
    logic [0:7]        pi_req;

    ebus_responder_fsm #(
        .DEV_CS     (DEV_CS),
        .XFER_DELAY (XFER_DELAY)
    ) u_fsm (
        .clk_i        (eboxClk),
        .rst_i        (eboxReset),
        .cs_i         (EBUS_cs),
        .func_i       (EBUS_func),
        .demand_i     (EBUS_demand),
        .func_o       (func),
        .xfer_o       (xfer),
        .drv_en_o     (drvEn),
        .enter_xfer_o (enter_xfer),
        .leave_xfer_o (leave_xfer)
    );

    // Only enable, done and PI level exist; every other CONI bit reads 0.
    assign conReg  = {12'b0, ie_q, 1'b0, done_q, pia_q};
    assign datReg  = dat_q;
    assign drvData = drv_data_q;
    assign piReq   = pi_req;

    // Register file: writes and read-data capture on the XFER entry edge,
    // bus data cleared on the edge that releases the bus.
    always_ff @(posedge eboxClk) begin
        // NOTE: datReg is visible and must read 0 after reset, so the data
        // register is reset along with the control bits.
        if (eboxReset) begin
            ie_q       <= 1'b0;
            done_q     <= 1'b0;
            pia_q      <= '0;
            dat_q      <= '0;
            drv_data_q <= '0;
        end else if (enter_xfer) begin
            case (func)
                FUNC_CONO: begin
                    ie_q  <= EBUS_dataIn[CON_IE_BIT];
                    pia_q <= EBUS_dataIn[CON_PIA_MSB:CON_PIA_LSB];
                    if (EBUS_dataIn[CON_CLR_DONE_BIT]) begin
                        done_q <= 1'b0;
                    end
                end
                FUNC_CONI: begin
                    drv_data_q <= {18'b0, conReg};
                end
                FUNC_DATAO: begin
                    dat_q  <= EBUS_dataIn;
                    done_q <= 1'b1;
                end
                FUNC_DATAI: begin
                    drv_data_q <= dat_q;
                    done_q     <= 1'b0;
                end
                default: begin
                end
            endcase
        end else if (leave_xfer) begin
            drv_data_q <= '0;
        end
    end

    // PI request: one-hot on the assigned level while done and enabled;
    // level 0 means no interrupt channel is assigned.
    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        pi_req = '0;
        if (ie_q && done_q && (pia_q != 3'd0)) begin
            pi_req[pia_q] = 1'b1;
        end
    end

`ifdef EBUS_RESP_PARITY_EN
    logic parity_err_q;
    logic bad_parity;

    // Odd parity: data plus parity bit must hold an odd number of ones.
    assign bad_parity = ~^{EBUS_dataIn, EBUS_parityIn};
    assign drvParity  = drvEn & ~^drv_data_q;
    assign parityErr  = parity_err_q;

    // Sticky parity error: set by a bad write, cleared by CONO bit 31.
    // The write itself still completes so software sees what arrived.
    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            parity_err_q <= 1'b0;
        end else if (enter_xfer && ((func == FUNC_CONO) || (func == FUNC_DATAO))) begin
            if (bad_parity) begin
                parity_err_q <= 1'b1;
            end else if ((func == FUNC_CONO) && EBUS_dataIn[CON_CLR_DONE_BIT]) begin
                parity_err_q <= 1'b0;
            end
        end
    end
`else
    // Parity disabled: no parity ports and no parity state.
`endif

endmodule
